// File: rtl/flasher_pkg.sv
// Shared types and helpers for the flasher flick scheduler slice.
package flasher_pkg;

    localparam int LED_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FLICK,
        WAIT_START,
        RUN,
        RELEASE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/flasher_flick_scheduler_if.sv
// Requester-side bus of the flick scheduler: requests, grants, flasher tap and status.
interface flasher_flick_scheduler_if
    import flasher_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LED_W   = flasher_pkg::LED_W
);
    // Handshake: req[i] is a level that may drop at any time; grant[i] is held for the
    // whole session once won; done[i] pulses for one cycle when that session ends
    // (grant is already low in that cycle). There is no ready/backpressure path.
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [LED_W-1:0]              leds_in;
    logic                          flick_out;
    logic                          busy;
    logic                          timeout_err;
    logic [clog2(NUM_REQ)-1:0]     owner_id;
    state_t                        state;

    modport master (
        output req, leds_in,
        input  grant, done, flick_out, busy, timeout_err, owner_id, state
    );

    modport slave (
        input  req, leds_in,
        output grant, done, flick_out, busy, timeout_err, owner_id, state
    );

endinterface

// File: rtl/flasher_rr_arbiter.sv
// Round-robin search over requesters starting at ptr, with the ptr register itself.
module flasher_rr_arbiter
    import flasher_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    // Scan from the farthest position back to ptr so the nearest set bit wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

    // Advancing at grant time gives the same pointer as advancing at release, since
    // the pointer is only consulted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/flasher_flick_scheduler.sv
// Shares one flasher between requesters: arbitrates, flicks it once, and watches its
// LED bus to decide when the owner's session is over (or has timed out).
module flasher_flick_scheduler
    import flasher_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int LED_W         = flasher_pkg::LED_W,
    parameter int IDLE_CYCLES   = 4,
    parameter int START_TIMEOUT = 16,
    parameter int RUN_TIMEOUT   = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    flasher_flick_scheduler_if.slave   bus
);

    localparam int OW   = clog2(NUM_REQ);
    localparam int CMAX = (START_TIMEOUT > RUN_TIMEOUT) ? START_TIMEOUT : RUN_TIMEOUT;
    localparam int CW   = clog2(CMAX + 1);
    localparam int ZW   = clog2(IDLE_CYCLES + 1);

    state_t             state;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               flick;
    logic               busy;
    logic               terr;
    logic [OW-1:0]      owner;
    logic [CW-1:0]      cnt;
    logic [ZW-1:0]      zcnt;
    logic [LED_W-1:0]   leds;
    logic [OW-1:0]      arb_winner;
    logic               arb_valid;
    logic               arb_advance;

    assign leds        = bus.leds_in;
    assign arb_advance = (state == IDLE) && arb_valid;

    flasher_rr_arbiter #(.N(NUM_REQ), .IW(OW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (arb_advance),
        .winner  (arb_winner),
        .valid   (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            flick <= 1'b0;
            busy  <= 1'b0;
            terr  <= 1'b0;
            owner <= '0;
            cnt   <= '0;
            zcnt  <= '0;
        end else begin
            flick <= 1'b0;
            done  <= '0;
            terr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state <= FLICK;
                        grant <= NUM_REQ'(1) << arb_winner;
                        owner <= arb_winner;
                        flick <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FLICK: begin
                    state <= WAIT_START;
                    cnt   <= '0;
                end
                WAIT_START: begin
                    if (leds != '0) begin
                        state <= RUN;
                        cnt   <= '0;
                        zcnt  <= '0;
                    end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
                        state <= RELEASE;
                        grant <= '0;
                        done  <= grant;
                        terr  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A normal end seen on the same edge as the run limit is not an error.
                    if (zcnt == ZW'(IDLE_CYCLES)) begin
                        state <= RELEASE;
                        grant <= '0;
                        done  <= grant;
                    end else if (cnt >= CW'(RUN_TIMEOUT - 1)) begin
                        state <= RELEASE;
                        grant <= '0;
                        done  <= grant;
                        terr  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (leds != '0)                  zcnt <= '0;
                        else if (zcnt < ZW'(IDLE_CYCLES)) zcnt <= zcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant;
    assign bus.done        = done;
    assign bus.flick_out   = flick;
    assign bus.busy        = busy;
    assign bus.timeout_err = terr;
    assign bus.owner_id    = owner;
    assign bus.state       = state;

endmodule

// File: doc/flasher_flick_scheduler.md
Name: flasher_flick_scheduler

Overview:
Shares one boundFlasher instance between NUM_REQ independent requesters. Arbitrates requests round-robin and issues the single-cycle flick pulse that starts the flasher. Watches the flasher's LED bus to decide when the owner's session has finished, and reports completion or timeout. Sits directly in front of boundFlasher: flick_out drives its flick input, and leds_in is tapped from its LEDs output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LED_W, 16, flasher LED bus width
IDLE_CYCLES, 4, consecutive all-zero LED cycles that mark end of session
START_TIMEOUT, 16, max cycles from flick to first nonzero LED
RUN_TIMEOUT, 1023, max cycles in RUN before forced release

Ports:
clk  in  1  rising-edge clock shared with boundFlasher
rst  in  1  asynchronous reset, active-high
req  in  NUM_REQ  level request per requester; may drop at any time
leds_in  in  LED_W  flasher LED bus (observed only)
flick_out  out  1  to flasher flick; one-cycle pulse
grant  out  NUM_REQ  one-hot owner, held for the whole session
done  out  NUM_REQ  one-cycle pulse to owner at session end
busy  out  1  high in any state other than IDLE
owner_id  out  clog2(NUM_REQ)  index of current/last owner
timeout_err  out  1  one-cycle pulse when a session is aborted by timeout

Behaviour:
- Reset (async, any state): state=IDLE; flick_out, grant, done, busy, timeout_err, owner_id, counters = 0; rr pointer = 0, so requester 0 has top priority.
- All outputs are registered.
- States: IDLE, FLICK, WAIT_START, RUN, RELEASE.
- IDLE, req≠0 at edge k:
  - Winner is the first set bit searching from ptr upward, with wrap.
  - After edge k: state=FLICK, grant=onehot(winner), owner_id=winner, flick_out=1, busy=1.
- FLICK: lasts exactly one cycle; flick_out=0 after the next edge. Next state is WAIT_START, with the cycle counter cleared.
- WAIT_START:
  - leds_in≠0 → RUN, counter cleared.
  - Counter reaches START_TIMEOUT → RELEASE with timeout flag.
- RUN:
  - zero_cnt increments while leds_in==0 and clears on any nonzero value.
  - zero_cnt==IDLE_CYCLES → RELEASE (normal). Single-cycle zeros at flasher phase boundaries must not end the session.
  - Run counter reaching RUN_TIMEOUT → RELEASE with timeout flag.
- RELEASE (one cycle):
  - done[owner]=1 and grant=0.
  - timeout_err=1 if the timeout flag is set.
  - ptr=owner+1 mod NUM_REQ.
  - Next state is IDLE.
  - There is always at least one IDLE cycle between sessions.
- flick_out is never asserted outside FLICK. The scheduler never re-flicks a running flasher.
- Owner dropping req mid-session: the session continues to completion and done still pulses. The flasher cannot be aborted except by its own reset.
- Non-owner requests during a session: ignored, not latched. They win only if still asserted when arbitration runs in IDLE.
- Requests arriving in the RELEASE cycle are evaluated in the following IDLE cycle.
- Counter widths: clog2(max+1); counters saturate and never wrap.
- owner_id holds its last value in IDLE.

Decomposition:
- Package flasher_pkg holds:
  - LED_W
  - state enum: IDLE, FLICK, WAIT_START, RUN, RELEASE
  - a clog2 function
- Sub-module flasher_rr_arbiter contains the round-robin search plus ptr register, with ports req, advance, winner, valid. The top module instantiates it and owns the FSM and counters.

Test Plan:
1. Reset, then req=4'b0001 for 1 cycle; model LEDs turning on 2 cycles after flick and going all-zero after 40 cycles.
   - Expect flick_out high exactly 1 cycle, one edge after req is sampled.
   - Expect grant=0001 until done[0] pulses IDLE_CYCLES+1 edges after the LEDs reach zero.
2. req=4'b1111 held continuously. Expect grant order 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between sessions.
3. In RUN, drive leds_in to 0 for 1 cycle three times, then nonzero again. Expect busy to stay 1, no done, and no second flick.
4. Flasher unconnected (leds_in=0) after flick. Expect timeout_err and done[owner] pulses 16 cycles after WAIT_START entry, then grant=0.
5. Assert rst mid-RUN for 3 cycles. Expect all outputs 0 immediately (async). After release, req=4'b1010 → grant=0010, proving ptr was reset to 0.
6. Owner drops req in WAIT_START, and req[2] rises during RUN. Expect done for the original owner first, then a grant to requester 2 one cycle after IDLE.
